// File: rtl/mem_io_pkg.sv
// Shared constants for the memory-mapped I/O bridge: register offsets and bit positions.
package mem_io_pkg;

   // I/O register offsets within the top four addresses of the data space
   localparam logic [1:0] OFF_OUT    = 2'd0;
   localparam logic [1:0] OFF_IN     = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   // STATUS register bit positions
   localparam int unsigned ST_RX_FULL  = 0;
   localparam int unsigned ST_TX_EMPTY = 1;
   localparam int unsigned ST_TX_FULL  = 2;
   localparam int unsigned ST_FAULT    = 3;
   localparam int unsigned ST_LOOP     = 4;

   // CTRL register bit positions
   localparam int unsigned CTRL_CLR_FAULT = 0;
   localparam int unsigned CTRL_LOOP      = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with head-of-queue output. A push while full is taken only
// when a pop happens in the same cycle; otherwise it is silently ignored here.
module sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              do_push, do_pop;

   assign full    = (cnt_q == CntW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_pop  = pop && !empty;
   // When full, the popped slot is the one being written, so the head is read before it is lost
   assign do_push = push && (!full || do_pop);
   assign head    = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; pointers wrap naturally at a power-of-two depth
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   // Pointer and occupancy registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates their use
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-mapped I/O bridge: top four data addresses map to OUT/IN/STATUS/CTRL registers,
// everything else passes through to RAM. Provides a TX FIFO, RX holding register,
// loopback mode and a sticky fault flag.
module mem_io_bridge
   import mem_io_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RAM_SIZE   = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [RAM_SIZE-1:0] cpu_addr,
   input  logic                cpu_we,
   input  logic [DATA_W-1:0]   cpu_wdata,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic [RAM_SIZE-1:0] ram_addr,
   output logic                ram_we,
   output logic [DATA_W-1:0]   ram_wdata,
   input  logic [DATA_W-1:0]   ram_rdata,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                fault
);

   logic              io_hit;
   logic [1:0]        off;
   logic              wr_out, wr_ctrl, rd_in;
   logic              tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_W-1:0] tx_head;
   logic              loop_move, rx_capture, overflow, underflow;
   logic [DATA_W-1:0] io_rdata;

   logic              rx_full_q, rx_full_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              loop_q, loop_d;
   logic              fault_q, fault_d;
   logic              rsp_io_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   // Address >= 2^RAM_SIZE-4 is exactly "all upper bits set"
   assign io_hit  = &cpu_addr[RAM_SIZE-1:2];
   assign off     = cpu_addr[1:0];
   assign wr_out  = io_hit && cpu_we && (off == OFF_OUT);
   assign wr_ctrl = io_hit && cpu_we && (off == OFF_CTRL);
   assign rd_in   = io_hit && !cpu_we && (off == OFF_IN);

   assign ram_addr  = cpu_addr;
   assign ram_wdata = cpu_wdata;
   assign ram_we    = cpu_we && !io_hit;

   // Stream handshakes are forced low while reset is asserted
   assign out_valid  = rst && !loop_q && !tx_empty;
   assign out_data   = tx_head;
   assign in_ready   = rst && !loop_q && !rx_full_q;
   assign rx_capture = in_valid && in_ready;
   assign loop_move  = loop_q && !tx_empty && !rx_full_q;

   assign tx_push   = wr_out;
   assign tx_pop    = (out_valid && out_ready) || loop_move;
   assign overflow  = tx_push && tx_full && !tx_pop;
   assign underflow = rd_in && !rx_full_q;

   assign fault     = fault_q;
   assign cpu_rdata = rsp_io_q ? rsp_rdata_q : ram_rdata;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (cpu_wdata),
      .head  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   // I/O register read value, sampled at the request edge
   always_comb begin
      io_rdata = '0;
      unique case (off)
         OFF_OUT:    io_rdata = '0;
         OFF_IN:     io_rdata = rx_data_q;
         OFF_STATUS: begin
            io_rdata[ST_RX_FULL]  = rx_full_q;
            io_rdata[ST_TX_EMPTY] = tx_empty;
            io_rdata[ST_TX_FULL]  = tx_full;
            io_rdata[ST_FAULT]    = fault_q;
            io_rdata[ST_LOOP]     = loop_q;
         end
         OFF_CTRL:   io_rdata[CTRL_LOOP] = loop_q;
      endcase
   end

   // Next state of RX register, loop mode and fault flag
   always_comb begin
      rx_full_d = rx_full_q;
      rx_data_d = rx_data_q;
      loop_d    = loop_q;
      fault_d   = fault_q;
      if (rd_in) rx_full_d = 1'b0;
      // Capture and loopback move need rx_full=0, so they never collide with a real pop
      if (rx_capture) begin
         rx_data_d = in_data;
         rx_full_d = 1'b1;
      end else if (loop_move) begin
         rx_data_d = tx_head;
         rx_full_d = 1'b1;
      end
      if (wr_ctrl) loop_d = cpu_wdata[CTRL_LOOP];
      if (wr_ctrl && cpu_wdata[CTRL_CLR_FAULT]) fault_d = 1'b0;
      // Setting wins over a simultaneous clear
      if (overflow || underflow) fault_d = 1'b1;
   end

   // Bridge state and one-cycle read response registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_full_q   <= 1'b0;
         rx_data_q   <= '0;
         loop_q      <= 1'b0;
         fault_q     <= 1'b0;
         rsp_io_q    <= 1'b1;
         rsp_rdata_q <= '0;
      end else begin
         rx_full_q   <= rx_full_d;
         rx_data_q   <= rx_data_d;
         loop_q      <= loop_d;
         fault_q     <= fault_d;
         rsp_io_q    <= io_hit;
         rsp_rdata_q <= io_rdata;
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a behavioural one-cycle RAM.
module tb_mem_io_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cpu_addr;
   logic        cpu_we;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic [7:0]  ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        fault;

   logic [15:0] ram_mem [256];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [15:0] rd;
   logic [15:0] exp_w [4];

   always #5 clk = ~clk;

   mem_io_bridge #(
      .DATA_W     (16),
      .RAM_SIZE   (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_we    (cpu_we),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fault     (fault)
   );

   // Synchronous RAM: read data valid one cycle after the address
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_bus();
      cpu_addr  = 8'h00;
      cpu_we    = 1'b0;
      cpu_wdata = 16'h0000;
   endtask

   task automatic cpu_write(input logic [7:0] addr, input logic [15:0] data);
      cpu_addr  = addr;
      cpu_we    = 1'b1;
      cpu_wdata = data;
      @(posedge clk);
      #1;
      idle_bus();
   endtask

   task automatic cpu_read(input logic [7:0] addr, output logic [15:0] data);
      cpu_addr = addr;
      cpu_we   = 1'b0;
      @(posedge clk);
      #1;
      data = cpu_rdata;
      idle_bus();
   endtask

   // Accept four words from the output stream and compare them in order
   task automatic drain(input string tag, input logic [15:0] w [4]);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_data"}, {16'd0, out_data}, {16'd0, w[i]});
         @(posedge clk);
         #1;
      end
      check({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      in_data   = 16'h0000;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      idle_bus();

      // Reset and RAM passthrough
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_rdata", {16'd0, cpu_rdata}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      cpu_write(8'h10, 16'h1234);
      cpu_read(8'h10, rd);
      check("ram_readback", {16'd0, rd}, 32'h1234);

      // TX stream fills FIFO, then drains in order
      for (int i = 0; i < 4; i++) cpu_write(8'hFC, 16'hA001 + 16'(i));
      cpu_read(8'hFE, rd);
      check("tx_status_full", {16'd0, rd}, 32'h0004);
      exp_w = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
      drain("tx", exp_w);

      // Overflow drops the word and sets fault; CTRL bit0 clears it
      for (int i = 0; i < 4; i++) cpu_write(8'hFC, 16'hB001 + 16'(i));
      check("pre_ovf_fault", {31'd0, fault}, 32'd0);
      cpu_addr  = 8'hFC;
      cpu_we    = 1'b1;
      cpu_wdata = 16'hBEEF;
      #1;
      check("io_write_ram_we", {31'd0, ram_we}, 32'd0);
      @(posedge clk);
      #1;
      idle_bus();
      check("ovf_fault", {31'd0, fault}, 32'd1);
      cpu_read(8'hFE, rd);
      check("ovf_status", {16'd0, rd}, 32'h000C);
      cpu_write(8'hFF, 16'h0001);
      check("ovf_clear", {31'd0, fault}, 32'd0);
      exp_w = '{16'hB001, 16'hB002, 16'hB003, 16'hB004};
      drain("ovf_drain", exp_w);

      // RX capture, pop and underflow
      in_data  = 16'h5A5A;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("rx_in_ready_low", {31'd0, in_ready}, 32'd0);
      cpu_read(8'hFD, rd);
      check("rx_data", {16'd0, rd}, 32'h5A5A);
      check("rx_in_ready_high", {31'd0, in_ready}, 32'd1);
      check("rx_no_fault", {31'd0, fault}, 32'd0);
      cpu_read(8'hFD, rd);
      check("udf_stale", {16'd0, rd}, 32'h5A5A);
      check("udf_fault", {31'd0, fault}, 32'd1);
      cpu_write(8'hFF, 16'h0001);
      check("udf_clear", {31'd0, fault}, 32'd0);

      // Loopback moves the FIFO head into the RX register
      cpu_write(8'hFF, 16'h0002);
      check("loop_in_ready", {31'd0, in_ready}, 32'd0);
      cpu_write(8'hFC, 16'h7777);
      check("loop_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      cpu_read(8'hFE, rd);
      check("loop_status", {16'd0, rd}, 32'h0013);
      cpu_read(8'hFD, rd);
      check("loop_rx_data", {16'd0, rd}, 32'h7777);
      cpu_read(8'hFF, rd);
      check("loop_ctrl", {16'd0, rd}, 32'h0002);
      check("loop_fault", {31'd0, fault}, 32'd0);
      cpu_write(8'hFF, 16'h0000);
      check("unloop_in_ready", {31'd0, in_ready}, 32'd1);

      // Push into a full FIFO while the sink pops in the same cycle
      for (int i = 0; i < 4; i++) cpu_write(8'hFC, 16'hD001 + 16'(i));
      out_ready = 1'b1;
      check("fp_head", {16'd0, out_data}, 32'hD001);
      cpu_write(8'hFC, 16'hC0DE);
      out_ready = 1'b0;
      check("fp_fault", {31'd0, fault}, 32'd0);
      cpu_read(8'hFE, rd);
      check("fp_status", {16'd0, rd}, 32'h0004);
      exp_w = '{16'hD002, 16'hD003, 16'hD004, 16'hC0DE};
      drain("fp_drain", exp_w);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
